mem_write_checker: RTL
======================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the monitored data address.
REQ-002 SHALL have parameter DATA_W, default 32, width of the monitored write data.
REQ-003 SHALL have parameter DEPTH, default 8, number of expected-write table entries.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1000, maximum RUN cycles before timeout fail.
REQ-005 SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  reset  in  1  synchronous, active-high.
  cfg_mode  in  1  0 = ORDERED (every write checked in sequence); 1 = TERMINAL (only final entry decides).
  cfg_exp_count  in  clog2(DEPTH+1)  number of valid table entries.
  cfg_ignore_en  in  1  enables ignore-address filter.
  cfg_ignore_addr  in  ADDR_W  writes to this address are skipped.
  load_en  in  1  table write strobe.
  load_idx  in  clog2(DEPTH)  table entry index.
  load_addr  in  ADDR_W  expected address.
  load_data  in  DATA_W  expected data.
  start  in  1  begin a check run.
  mon_memwrite  in  1  observed store strobe.
  mon_addr  in  ADDR_W  observed address.
  mon_data  in  DATA_W  observed data.
  busy  out  1  high in RUN.
  pass  out  1  sticky success.
  fail  out  1  sticky failure.
  fail_cause  out  2  0 NONE, 1 MISMATCH, 2 UNEXPECTED, 3 TIMEOUT.
  fail_idx  out  clog2(DEPTH)  table index expected when the failure occurred.
  match_count  out  clog2(DEPTH+1)  entries matched so far.
  cycle_count  out  32  RUN cycles elapsed, saturating.

Function
REQ-006 SHALL implement states IDLE, RUN, PASS, FAIL; all outputs registered.
REQ-007 SHALL write the table on load_en only in IDLE/PASS/FAIL; load_en in RUN is ignored.
REQ-008 SHALL move IDLE/PASS/FAIL -> RUN on start; clear match_count, cycle_count, fail_cause, fail_idx, pass and fail on that edge.
REQ-009 SHALL, when load_en and start coincide, commit the load and make the loaded entry valid for the run.
REQ-010 SHALL clamp an effective count of cfg_exp_count above DEPTH to DEPTH; a count of 0 goes RUN -> PASS on the first RUN cycle.
REQ-011 SHALL sample a write only when mon_memwrite=1 in RUN; a write with cfg_ignore_en=1 and mon_addr==cfg_ignore_addr is dropped in both modes.
REQ-012 SHALL, in ORDERED mode, compare a sampled write against entry[match_count]: on a full address+data match, increment; on match of the last entry, go to PASS; otherwise go to FAIL, cause MISMATCH.
REQ-013 SHALL, in TERMINAL mode, go to PASS on a write equal to entry[count-1], and to FAIL with cause UNEXPECTED on any other non-ignored write.
REQ-014 SHALL assert pass/fail on the cycle after the deciding write is sampled (latency 1), hold it until start or reset, and never assert both.
REQ-015 SHALL increment cycle_count every RUN cycle, saturating at all-ones; on reaching TIMEOUT_CYC in RUN, go to FAIL with cause TIMEOUT.
REQ-016 SHALL, when a deciding write and the timeout coincide, let the write decide.
REQ-017 SHALL set fail_idx to match_count at the failing edge.
REQ-018 SHALL drive busy=1 only in RUN.

Reset
REQ-019 SHALL on reset go to IDLE with busy=0, pass=0, fail=0, fail_cause=0, fail_idx=0, match_count=0 and cycle_count=0, including mid-RUN.
REQ-020 SHALL retain table contents through reset; the table has no reset value.

Structure
REQ-021 SHALL place the state enum, fail_cause codes and mode constants in the shared package chk_pkg.
REQ-022 SHALL use one sub-module, chk_exp_table: a DEPTH x (ADDR_W+DATA_W) register file with one synchronous write port and one combinational read port.

Verification
REQ-023 TERMINAL, count=1, entry0=(100,25), ignore 96: writes (96,7),(96,9),(100,25) -> pass=1 one cycle later, fail=0.
REQ-024 TERMINAL, same configuration: write (104,25) -> fail=1, fail_cause=2.
REQ-025 ORDERED, count=3, entries (0,1),(4,2),(8,3): writes (0,1),(4,5) -> fail=1, cause=1, fail_idx=1, match_count=1.
REQ-026 ORDERED, TIMEOUT_CYC=20, no writes -> fail=1, cause=3 at cycle_count=20; deciding write on cycle 20 -> pass.
REQ-027 Reset asserted mid-RUN after 2 matches, then start -> match_count=0 and the table is still intact; the full sequence passes.
REQ-028 start with count=0 -> pass=1 after the first RUN cycle; load_en during RUN leaves the entry unchanged.

Source files
------------

// File: rtl/chk_pkg.sv
// chk_pkg: shared state, failure-cause and mode encodings for the write checker
package chk_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;
    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISMATCH   = 2'd1;
    localparam logic [1:0] CAUSE_UNEXPECTED = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;
    localparam logic MODE_ORDERED  = 1'b0;
    localparam logic MODE_TERMINAL = 1'b1;
endpackage

// File: rtl/chk_exp_table.sv
// chk_exp_table: expected-write register file, one sync write port, one comb read port
module chk_exp_table #(
    parameter int DEPTH = 8,
    parameter int W = 64,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] ridx,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we && int'(widx) < DEPTH) mem[widx] <= wdata;

    assign rdata = (int'(ridx) < DEPTH) ? mem[ridx] : '0;
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks monitored stores against a table of expected writes
module mem_write_checker
    import chk_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH = 8,
    parameter int TIMEOUT_CYC = 1000,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_mode,
    input  logic [CW-1:0]     cfg_exp_count,
    input  logic              cfg_ignore_en,
    input  logic [ADDR_W-1:0] cfg_ignore_addr,
    input  logic              load_en,
    input  logic [IW-1:0]     load_idx,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              mon_memwrite,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_data,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_cause,
    output logic [IW-1:0]     fail_idx,
    output logic [CW-1:0]     match_count,
    output logic [31:0]       cycle_count
);
    state_t                     state;
    logic                       mode;
    logic [CW-1:0]              cnt;
    logic [IW-1:0]              rd_idx;
    logic [ADDR_W+DATA_W-1:0]   exp_entry;
    logic                       sampled, hit, last, timeout;

    // TERMINAL mode only ever compares against the final entry
    assign rd_idx  = IW'((mode == MODE_TERMINAL) ? cnt - 1'b1 : match_count);
    assign sampled = mon_memwrite && !(cfg_ignore_en && mon_addr == cfg_ignore_addr);
    assign hit     = {mon_addr, mon_data} == exp_entry;
    assign last    = match_count == cnt - 1'b1;
    assign timeout = 33'(cycle_count) + 33'd1 >= 33'(TIMEOUT_CYC);

    chk_exp_table #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_table (
        .clk   (clk),
        .we    (load_en && state != ST_RUN),
        .widx  (load_idx),
        .wdata ({load_addr, load_data}),
        .ridx  (rd_idx),
        .rdata (exp_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode        <= MODE_ORDERED;
            cnt         <= '0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_cause  <= CAUSE_NONE;
            fail_idx    <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end else if (state == ST_RUN) begin
            cycle_count <= (&cycle_count) ? cycle_count : cycle_count + 1'b1;
            if (cnt == '0) begin
                state <= ST_PASS;
                busy  <= 1'b0;
                pass  <= 1'b1;
            end else if (sampled && (mode == MODE_TERMINAL || !hit || last)) begin
                // a deciding write takes priority over a coincident timeout
                state <= hit ? ST_PASS : ST_FAIL;
                busy  <= 1'b0;
                pass  <= hit;
                fail  <= !hit;
                if (hit && mode == MODE_ORDERED) match_count <= match_count + 1'b1;
                if (!hit) begin
                    fail_cause <= (mode == MODE_TERMINAL) ? CAUSE_UNEXPECTED : CAUSE_MISMATCH;
                    fail_idx   <= IW'(match_count);
                end
            end else begin
                if (sampled) match_count <= match_count + 1'b1;
                if (timeout) begin
                    state      <= ST_FAIL;
                    busy       <= 1'b0;
                    fail       <= 1'b1;
                    fail_cause <= CAUSE_TIMEOUT;
                    fail_idx   <= IW'(match_count);
                end
            end
        end else if (start) begin
            state       <= ST_RUN;
            mode        <= cfg_mode;
            cnt         <= (cfg_exp_count > CW'(DEPTH)) ? CW'(DEPTH) : cfg_exp_count;
            busy        <= 1'b1;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_cause  <= CAUSE_NONE;
            fail_idx    <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end
    end
endmodule
